gate_eval_sched: RTL and testbench

Round-robin scheduler that shares one combinational gate-evaluation unit among NUM_REQ requesters. The unit computes out_1 = in_1 & in_2 & in_3 and out_2 = (in_1 & in_2) | in_3. Each cycle the block grants at most one requester, drives that requester's 3-bit operand into the unit and captures the two results, tagged with the requester ID, into a 2-entry response FIFO. The block sits between the requester fabric and the shared unit, and is the only driver of the unit's inputs.

---
 rtl/gate_eval_sched.sv | 147 ++++++++++++++
 tb/tb_gate_eval_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_sched.sv
// Round-robin scheduler sharing one gate-evaluation unit among NUM_REQ requesters,
// with a 2-entry tagged response FIFO. Define GATE_SCHED_STATS_EN for per-requester grant counters.
module gate_eval_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3*NUM_REQ-1:0]   req_data,
  output logic                   eu_in_1,
  output logic                   eu_in_2,
  output logic                   eu_in_3,
  input  logic                   eu_out_1,
  input  logic                   eu_out_2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_out_1,
  output logic                   rsp_out_2
`ifdef GATE_SCHED_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [NUM_REQ*CNT_W-1:0] stat_grants
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("gate_eval_sched: NUM_REQ must be in 2..8");
  end
  if (NUM_REQ > (1 << ID_W)) begin : g_bad_id_w
    $error("gate_eval_sched: ID_W too narrow for NUM_REQ");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("gate_eval_sched: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_t;

  occ_t                  r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_id [2];
  logic [1:0]            r_o1;
  logic [1:0]            r_o2;
  logic                  r_wr;
  logic                  r_rd;

  logic [2*NUM_REQ-1:0]  w_dbl;
  logic                  w_any;
  logic [ID_W-1:0]       w_gnt;
  logic                  w_grant;
  logic                  w_pop;
  logic [2:0]            w_op;

  // Rotating the doubled request vector by ptr makes bit k the (ptr+k)-th candidate.
  always_comb begin
    w_dbl = {req_valid, req_valid} >> r_ptr;
    w_any = 1'b0;
    w_gnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_dbl[k]) begin
        w_any = 1'b1;
        w_gnt = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // rst_n gates the grant so req_ready and operands are quiet throughout reset.
  assign w_grant = w_any && (r_state != S_TWO) && rst_n;
  assign w_pop   = rsp_valid && rsp_ready;

  always_comb begin
    req_ready = '0;
    w_op      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant && (w_gnt == ID_W'(k))) begin
        req_ready[k] = 1'b1;
        w_op         = req_data[3*k +: 3];
      end
    end
  end

  assign eu_in_1 = w_op[0];
  assign eu_in_2 = w_op[1];
  assign eu_in_3 = w_op[2];

  assign rsp_valid = (r_state != S_EMPTY);
  assign rsp_id    = r_id[r_rd];
  assign rsp_out_1 = r_o1[r_rd];
  assign rsp_out_2 = r_o2[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_id[0] <= '0;
      r_id[1] <= '0;
      r_o1    <= '0;
      r_o2    <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_id[r_wr] <= w_gnt;
        r_o1[r_wr] <= eu_out_1;
        r_o2[r_wr] <= eu_out_2;
        r_wr       <= ~r_wr;
        r_ptr      <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
      end
      if (w_pop) r_rd <= ~r_rd;
      case (r_state)
        S_EMPTY: if (w_grant) r_state <= S_ONE;
        S_ONE: begin
          if (w_grant && !w_pop)      r_state <= S_TWO;
          else if (w_pop && !w_grant) r_state <= S_EMPTY;
        end
        S_TWO:   if (w_pop) r_state <= S_ONE;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef GATE_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stat [NUM_REQ];

  // Clear takes priority, so a grant coinciding with stat_clr is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) r_stat[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (stat_clr)                            r_stat[k] <= '0;
        else if (req_ready[k] && req_valid[k] && (r_stat[k] != '1))
                                                 r_stat[k] <= r_stat[k] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) stat_grants[k*CNT_W +: CNT_W] = r_stat[k];
  end
`endif

endmodule

// File: tb/tb_gate_eval_sched.sv
// Randomized scoreboard bench for gate_eval_sched: a round-robin/occupancy model predicts
// grants and pushes expected responses; an independent monitor checks every popped response.
module tb_gate_eval_sched;

`ifdef GATE_SCHED_STATS_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_data;
  logic        eu_in_1, eu_in_2, eu_in_3;
  logic        eu_out_1, eu_out_2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_out_1, rsp_out_2;
`ifdef GATE_SCHED_STATS_EN
  logic        stat_clr;
  logic [4*CW-1:0] stat_grants;
  int          m_stat [4];
`endif

  gate_eval_sched #(.NUM_REQ(4), .ID_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .eu_in_1(eu_in_1), .eu_in_2(eu_in_2), .eu_in_3(eu_in_3),
    .eu_out_1(eu_out_1), .eu_out_2(eu_out_2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out_1(rsp_out_1), .rsp_out_2(rsp_out_2)
`ifdef GATE_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
  );

  // The shared gate unit itself.
  assign eu_out_1 = eu_in_1 & eu_in_2 & eu_in_3;
  assign eu_out_2 = (eu_in_1 & eu_in_2) | eu_in_3;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       o1;
    logic       o2;
  } rsp_t;

  rsp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, predict and check before the next posedge.
  task automatic step(input logic [3:0] v, input logic [11:0] d, input logic rr, input logic clr);
    int         g;
    logic [3:0] exp_rdy;
    logic [2:0] op;
    logic       pop;
    @(posedge clk);
    #1;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
`ifdef GATE_SCHED_STATS_EN
    stat_clr  = clr;
`endif
    @(negedge clk);
    #2;
    g = -1;
    if (m_cnt < 2)
      for (int k = 0; k < 4; k++)
        if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    exp_rdy = '0;
    op      = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      op         = d[3*g +: 3];
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("eu_in", 32'({eu_in_3, eu_in_2, eu_in_1}), 32'(op));
    check("rsp_valid", 32'(rsp_valid), 32'(m_cnt != 0));
`ifdef GATE_SCHED_STATS_EN
    for (int k = 0; k < 4; k++)
      check($sformatf("stat_grants[%0d]", k), 32'(stat_grants[k*CW +: CW]), 32'(m_stat[k]));
    if (clr) begin
      for (int k = 0; k < 4; k++) m_stat[k] = 0;
    end else if (g >= 0 && m_stat[g] < (1 << CW) - 1) begin
      m_stat[g]++;
    end
`else
    if (clr) n_cmp = n_cmp + 0;
`endif
    pop = (m_cnt != 0) && rr;
    if (g >= 0) begin
      sbq.push_back('{id: 2'(g), o1: &op, o2: (op[0] & op[1]) | op[2]});
      m_ptr = (g + 1) % 4;
      m_cnt++;
    end
    if (pop) m_cnt--;
  endtask

  task automatic model_reset();
    sbq.delete();
    m_ptr = 0;
    m_cnt = 0;
`ifdef GATE_SCHED_STATS_EN
    for (int k = 0; k < 4; k++) m_stat[k] = 0;
`endif
  endtask

  // Monitor: every accepted response must match the oldest predicted one.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          e = sbq.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_out_1", 32'(rsp_out_1), 32'(e.o1));
          check("rsp_out_2", 32'(rsp_out_2), 32'(e.o2));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '1;
    rsp_ready = 1'b1;
`ifdef GATE_SCHED_STATS_EN
    stat_clr  = 1'b0;
`endif
    model_reset();
    #13;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_eu_in", 32'({eu_in_3, eu_in_2, eu_in_1}), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_out", 32'({rsp_out_2, rsp_out_1}), 32'(0));
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2 with all-ones operand.
    step(4'b0100, 12'b000_111_000_000, 1'b1, 1'b0);
    // Fairness with everyone requesting.
    for (int i = 0; i < 8; i++) step(4'b1111, 12'($urandom), 1'b1, 1'b0);
    // Operand truth table through requester 1.
    for (int k = 0; k < 8; k++) step(4'b0010, 12'(k << 3), 1'b1, 1'b0);
    // Backpressure then release: two grants, stall, pop, bubble, streaming.
    for (int i = 0; i < 4; i++) step(4'b1111, 12'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b1111, 12'($urandom), 1'b1, 1'b0);

    // Fill the FIFO, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) step(4'b1111, 12'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_req_ready", 32'(req_ready), 32'(0));
    model_reset();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 12'($urandom), 1'b1, 1'b0);

    // Saturating counter on requester 3, then a clear with a coincident grant.
    for (int i = 0; i < 5; i++) step(4'b1000, 12'($urandom), 1'b1, 1'b0);
    step(4'b1000, 12'($urandom), 1'b1, 1'b1);
    step(4'b0000, 12'($urandom), 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 12'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));

    // Drain.
    for (int i = 0; i < 4; i++) step(4'b0000, 12'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(sbq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
